// File: rtl/iomem_router.sv
// iomem_router: routes one CPU iomem transaction at a time to a decoded peripheral slot.
// Optional access timeout enabled by defining IOMEM_ROUTER_TIMEOUT_EN.
module iomem_router #(
    parameter int         NUM_PORTS      = 4,
    parameter logic [7:0] BASE_HI        = 8'h03,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_valid,
    output logic                    m_ready,
    input  logic [3:0]              m_wstrb,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    output logic [31:0]             m_rdata,
    output logic [NUM_PORTS-1:0]    s_valid,
    input  logic [NUM_PORTS-1:0]    s_ready,
    output logic [3:0]              s_wstrb,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    input  logic [32*NUM_PORTS-1:0] s_rdata,
    output logic                    err_irq,
    output logic [31:0]             err_addr
);

    if (NUM_PORTS < 1 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("iomem_router: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [2:0]           sel;
    logic [7:0]           offset;
    logic                 hit;
    logic [NUM_PORTS-1:0] onehot;
    logic                 sel_ready;
    logic [31:0]          sel_rdata;
    logic                 expire;
    logic                 do_latch;
    logic                 do_miss;
    logic                 do_capture;
    logic                 do_timeout;

    // Slot k decodes at BASE_HI+k; 8-bit subtraction keeps the window contiguous.
    always_comb begin
        offset = m_addr[31:24] - BASE_HI;
        hit    = int'(offset) < NUM_PORTS;
        onehot = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            onehot[k] = (offset == 8'(k));
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (sel == 3'(k)) begin
                sel_ready = s_ready[k];
                sel_rdata = s_rdata[32*k +: 32];
            end
        end
    end

`ifdef IOMEM_ROUTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (do_latch) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign expire = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // s_ready is checked before expiry so a coincident completion is never an error.
    always_comb begin
        next_state = state;
        do_latch   = 1'b0;
        do_miss    = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (m_valid) begin
                    if (hit) begin
                        do_latch   = 1'b1;
                        next_state = ACCESS;
                    end else begin
                        do_miss    = 1'b1;
                        next_state = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    do_capture = 1'b1;
                    next_state = RESP;
                end else if (expire) begin
                    do_timeout = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign m_ready = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= '0;
            s_valid  <= '0;
            s_wstrb  <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            m_rdata  <= '0;
            err_irq  <= 1'b0;
            err_addr <= '0;
        end else begin
            err_irq <= do_miss | do_timeout;
            if (do_latch) begin
                sel     <= offset[2:0];
                s_valid <= onehot;
                s_wstrb <= m_wstrb;
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
            end
            if (do_capture || do_timeout) begin
                s_valid <= '0;
            end
            if (do_miss) begin
                m_rdata  <= '0;
                err_addr <= m_addr;
            end
            if (do_capture) begin
                m_rdata <= sel_rdata;
            end
            if (do_timeout) begin
                m_rdata  <= 32'hDEAD_BEEF;
                err_addr <= s_addr;
            end
        end
    end

endmodule
